// File: rtl/yv_row_sequencer.sv
// yv_row_sequencer: walks matrix Y (row-major) against vector V in SRAM and
// issues one Y/V read pair per cycle. It drives the accumulator controls,
// aligned to the multiplier output. When a row is finished it latches the
// accumulator sum and presents it with a one-cycle valid pulse.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for start; operands are sampled here only
// ISSUE    | N read cycles for the current row, one column per cycle
// DRAIN    | waiting 1+MULT_LAT+ACC_LAT cycles for the row sum to settle
// CAPTURE  | latch acc_out as the row result, then advance or finish
// DONE     | one-cycle done pulse, then back to IDLE
module yv_row_sequencer #(
  parameter int N        = 8,
  parameter int ADDR_W   = 6,
  parameter int ROW_W    = 4,
  parameter int DATA_W   = 48,
  parameter int MULT_LAT = 2,
  parameter int ACC_LAT  = 3
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [ROW_W-1:0]  i_num_rows,
  input  logic [ADDR_W-1:0] i_y_base,
  input  logic [ADDR_W-1:0] i_v_base,
  output logic              o_sram_rd_en,
  output logic [ADDR_W-1:0] o_y_addr,
  output logic [ADDR_W-1:0] o_v_addr,
  output logic              o_acc_enable,
  output logic              o_acc_chain,
  output logic              o_acc_sel_even,
  input  logic [DATA_W-1:0] i_acc_out,
  output logic [DATA_W-1:0] o_result,
  output logic [ROW_W-1:0]  o_result_row,
  output logic              o_result_valid,
  output logic              o_busy,
  output logic              o_done
);

  localparam int COL_W     = $clog2(N);
  localparam int DRAIN_CYC = 1 + MULT_LAT + ACC_LAT;
  localparam int DRAIN_W   = $clog2(DRAIN_CYC + 1);
  localparam int PIPE_D    = 1 + MULT_LAT;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [COL_W-1:0]    r_col;
  logic [DRAIN_W-1:0]  r_drain;
  logic [ROW_W-1:0]    r_row;
  logic [ROW_W-1:0]    r_num_rows;
  logic [ADDR_W-1:0]   r_row_ptr;
  logic [ADDR_W-1:0]   r_v_base;
  logic [DATA_W-1:0]   r_result;
  logic [ROW_W-1:0]    r_result_row;
  logic                r_result_valid;
  logic [PIPE_D-1:0]   r_pipe_vld;
  logic [PIPE_D-1:0]   r_pipe_first;
  logic [PIPE_D-1:0]   r_pipe_even;

  logic                w_rd_en;
  logic                w_last_col;
  logic                w_last_row;
  logic                w_drain_tc;

  assign w_rd_en    = (r_state == S_ISSUE);
  assign w_last_col = (r_col == COL_W'(N - 1));
  assign w_last_row = (r_row == (r_num_rows - ROW_W'(1)));
  assign w_drain_tc = (r_drain == '0);

  // State register
  always_ff @(posedge i_clock) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_state_nxt = (i_num_rows == '0) ? S_DONE : S_ISSUE;
      end
      S_ISSUE: begin
        if (w_last_col) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_drain_tc) w_state_nxt = S_CAPTURE;
      end
      S_CAPTURE: begin
        w_state_nxt = w_last_row ? S_DONE : S_ISSUE;
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Job operands, column/row counters, drain timer and result latch
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_col          <= '0;
      r_drain        <= '0;
      r_row          <= '0;
      r_num_rows     <= '0;
      r_row_ptr      <= '0;
      r_v_base       <= '0;
      r_result       <= '0;
      r_result_row   <= '0;
      r_result_valid <= 1'b0;
    end else begin
      r_result_valid <= (r_state == S_CAPTURE);
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_num_rows <= i_num_rows;
            r_row_ptr  <= i_y_base;
            r_v_base   <= i_v_base;
            r_row      <= '0;
            r_col      <= '0;
          end
        end
        S_ISSUE: begin
          if (w_last_col) begin
            r_col   <= '0;
            r_drain <= DRAIN_W'(DRAIN_CYC - 1);
          end else begin
            r_col   <= r_col + COL_W'(1);
          end
        end
        S_DRAIN: begin
          if (!w_drain_tc) r_drain <= r_drain - DRAIN_W'(1);
        end
        S_CAPTURE: begin
          r_result     <= i_acc_out;
          r_result_row <= r_row;
          if (!w_last_row) begin
            r_row     <= r_row + ROW_W'(1);
            r_row_ptr <= r_row_ptr + ADDR_W'(N);
          end
        end
        default: ;
      endcase
    end
  end

  // Tags each read with {valid, first column, even column}. The tag reaches
  // the accumulator controls together with the product of that read.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_pipe_vld   <= '0;
      r_pipe_first <= '0;
      r_pipe_even  <= '0;
    end else begin
      r_pipe_vld[0]   <= w_rd_en;
      r_pipe_first[0] <= w_rd_en & (r_col == '0);
      r_pipe_even[0]  <= w_rd_en & ~r_col[0];
      for (int i = 1; i < PIPE_D; i++) begin
        r_pipe_vld[i]   <= r_pipe_vld[i-1];
        r_pipe_first[i] <= r_pipe_first[i-1];
        r_pipe_even[i]  <= r_pipe_even[i-1];
      end
    end
  end

  // Addresses are forced to zero outside ISSUE so that idle outputs read as 0
  assign o_sram_rd_en   = w_rd_en;
  assign o_y_addr       = w_rd_en ? (r_row_ptr + ADDR_W'(r_col)) : '0;
  assign o_v_addr       = w_rd_en ? (r_v_base + ADDR_W'(r_col)) : '0;
  assign o_acc_enable   = r_pipe_vld[PIPE_D-1];
  assign o_acc_chain    = r_pipe_vld[PIPE_D-1] & ~r_pipe_first[PIPE_D-1];
  assign o_acc_sel_even = r_pipe_vld[PIPE_D-1] & r_pipe_even[PIPE_D-1];
  assign o_result       = r_result;
  assign o_result_row   = r_result_row;
  assign o_result_valid = r_result_valid;
  assign o_busy         = (r_state != S_IDLE);
  assign o_done         = (r_state == S_DONE);

endmodule

// File: tb/tb_yv_row_sequencer.sv
// Bench for yv_row_sequencer. It uses behavioural SRAM, multiplier and
// accumulator models. A scoreboard holds the expected reads, controls,
// row results and done pulses.
module tb_yv_row_sequencer;
  localparam int N  = 4;
  localparam int AW = 6;
  localparam int RW = 4;
  localparam int DW = 48;
  localparam int ML = 2;
  localparam int AL = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [RW-1:0] num_rows = '0;
  logic [AW-1:0] y_base = '0;
  logic [AW-1:0] v_base = '0;
  logic          rd_en, acc_enable, acc_chain, acc_sel_even;
  logic [AW-1:0] y_addr, v_addr;
  logic [DW-1:0] acc_out;
  logic [DW-1:0] result;
  logic [RW-1:0] result_row;
  logic          result_valid, busy, done;

  always #5 clk = ~clk;

  yv_row_sequencer #(
    .N(N), .ADDR_W(AW), .ROW_W(RW), .DATA_W(DW), .MULT_LAT(ML), .ACC_LAT(AL)
  ) dut (
    .i_clock(clk), .i_reset(reset), .i_start(start), .i_num_rows(num_rows),
    .i_y_base(y_base), .i_v_base(v_base), .o_sram_rd_en(rd_en),
    .o_y_addr(y_addr), .o_v_addr(v_addr), .o_acc_enable(acc_enable),
    .o_acc_chain(acc_chain), .o_acc_sel_even(acc_sel_even), .i_acc_out(acc_out),
    .o_result(result), .o_result_row(result_row), .o_result_valid(result_valid),
    .o_busy(busy), .o_done(done)
  );

  // Datapath models: SRAM read latency 1, multiplier latency 2, and an
  // accumulator whose final sum lands on acc_out 3 cycles after the last product.
  logic [7:0]    y_mem [64];
  logic [7:0]    v_mem [64];
  logic [7:0]    yq = '0, vq = '0;
  logic [DW-1:0] p1 = '0, p2 = '0, sum = '0, a1 = '0;
  initial acc_out = '0;

  always @(posedge clk) begin
    if (rd_en) begin
      yq <= y_mem[y_addr];
      vq <= v_mem[v_addr];
    end
    p1 <= DW'(yq) * DW'(vq);
    p2 <= p1;
    if (acc_enable) sum <= acc_chain ? sum + p2 : p2;
    a1      <= sum;
    acc_out <= a1;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail(input string nm, input string what);
    checks++;
    errors++;
    $display("FAIL %s %s t=%0t", nm, what, $time);
  endtask

  // Scoreboard queues
  logic [2*AW-1:0]  addr_q [$];
  logic [1:0]       ctl_q  [$];
  logic [DW+RW-1:0] res_q  [$];
  int               done_q [$];

  function automatic logic [DW-1:0] row_sum(input int yb, input int vb, input int r);
    logic [DW-1:0] s;
    s = '0;
    for (int c = 0; c < N; c++)
      s += DW'(y_mem[(yb + r * N + c) % 64]) * DW'(v_mem[(vb + c) % 64]);
    return s;
  endfunction

  // Monitor: pops the scoreboard whenever the DUT presents something
  logic [2:0] hist = '0;
  logic       prev_done = 1'b0;

  always @(negedge clk) begin
    logic [2*AW-1:0]  ea;
    logic [1:0]       ec;
    logic [DW+RW-1:0] er;
    int               rows;
    if (reset) begin
      addr_q.delete();
      ctl_q.delete();
      res_q.delete();
      done_q.delete();
      hist = '0;
      prev_done = 1'b0;
    end else begin
      if (rd_en) begin
        if (addr_q.size() == 0) fail("rd_unexpected", "read with none expected");
        else begin
          ea = addr_q.pop_front();
          chk("rd_addr_yv", {y_addr, v_addr}, ea);
        end
      end
      chk("acc_en_align", acc_enable, hist[2]);
      hist = {hist[1:0], rd_en};
      if (acc_enable) begin
        if (ctl_q.size() == 0) fail("acc_unexpected", "acc_enable with none expected");
        else begin
          ec = ctl_q.pop_front();
          chk("acc_chain", acc_chain, !ec[1]);
          chk("acc_sel_even", acc_sel_even, ec[0]);
        end
      end else begin
        chk("acc_ctl_idle", {acc_chain, acc_sel_even}, 2'b00);
      end
      if (result_valid) begin
        if (res_q.size() == 0) fail("res_unexpected", "result_valid with none expected");
        else begin
          er = res_q.pop_front();
          chk("result", result, er[DW+RW-1:RW]);
          chk("result_row", result_row, er[RW-1:0]);
        end
      end
      if (done) begin
        if (done_q.size() == 0) fail("done_unexpected", "done with none expected");
        else begin
          rows = done_q.pop_front();
          chk("done_busy", busy, 1'b1);
          if (rows != 0) chk("done_with_last_result", result_valid, 1'b1);
        end
      end
      if (prev_done) chk("busy_after_done", busy, 1'b0);
      prev_done = done;
    end
  end

  task automatic check_zero(input string nm);
    chk({nm, "_ctl"}, {rd_en, y_addr, v_addr, acc_enable, acc_chain, acc_sel_even,
                       result_valid, busy, done, result_row}, '0);
    chk({nm, "_res"}, result, '0);
  endtask

  task automatic randomize_mem();
    for (int i = 0; i < 64; i++) begin
      y_mem[i] = 8'($urandom);
      v_mem[i] = 8'($urandom);
    end
  endtask

  task automatic run_job(input int rows, input int yb, input int vb, input bit rnd);
    logic [AW-1:0] ya, va;
    logic [RW-1:0] rr;
    if (rnd) randomize_mem();
    @(posedge clk); #1;
    start = 1'b1;
    num_rows = RW'(rows);
    y_base = AW'(yb);
    v_base = AW'(vb);
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < N; c++) begin
        ya = AW'((yb + r * N + c) % 64);
        va = AW'((vb + c) % 64);
        addr_q.push_back({ya, va});
        ctl_q.push_back({c == 0, (c % 2) == 0});
      end
      rr = RW'(r);
      res_q.push_back({row_sum(yb, vb, r), rr});
    end
    done_q.push_back(rows);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) fail("done_timeout", "no done within budget");
  endtask

  initial begin
    bit hit;
    randomize_mem();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset_state");
    @(posedge clk); #1;
    reset = 1'b0;

    // Directed single-row job: 1*1 + 2*1 + 3*1 + 4*1
    for (int i = 0; i < 4; i++) begin
      y_mem[i]      = 8'(i + 1);
      v_mem[32 + i] = 8'd1;
    end
    run_job(1, 0, 32, 1'b0);
    wait_done(200);

    // Three rows from y_base 8
    run_job(3, 8, int'($urandom_range(0, 63)), 1'b1);
    wait_done(200);

    // Zero rows: done one cycle after start, no reads or results
    run_job(0, 5, 9, 1'b1);
    @(negedge clk);
    chk("zero_rows_done", done, 1'b1);

    // Address wrap on both ports
    run_job(1, 62, 63, 1'b1);
    wait_done(200);

    // start re-pulsed during ISSUE and DRAIN is ignored
    run_job(2, 20, 5, 1'b1);
    @(posedge clk); #1;
    start = 1'b1; num_rows = 4'd7; y_base = 6'd40; v_base = 6'd1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1; num_rows = 4'd3; y_base = 6'd33; v_base = 6'd17;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(200);

    // Reset in the second ISSUE cycle of row 1 aborts the job
    run_job(2, 10, 50, 1'b1);
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(posedge clk); #1;
      if (rd_en && y_addr == 6'd15) hit = 1'b1;
    end
    if (!hit) fail("abort_point_timeout", "row 1 col 1 read never seen");
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_zero("abort_state");
    repeat (20) @(negedge clk);
    run_job(1, 10, 50, 1'b1);
    wait_done(200);

    // Randomized jobs
    for (int k = 0; k < 8; k++) begin
      run_job(int'($urandom_range(1, 4)), int'($urandom_range(0, 63)),
              int'($urandom_range(0, 63)), 1'b1);
      wait_done(200);
    end

    repeat (6) @(negedge clk);
    chk("addr_q_empty", 64'(addr_q.size()), 64'd0);
    chk("ctl_q_empty", 64'(ctl_q.size()), 64'd0);
    chk("res_q_empty", 64'(res_q.size()), 64'd0);
    chk("done_q_empty", 64'(done_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
